id_ex_stage: RTL and testbench

ID/EX pipeline stage of the MIPS datapath, sitting directly upstream of the ALU. It registers decoded operands and controls, and derives the 3-bit ALU select from ALUOp/funct. It also resolves RAW hazards by forwarding from EX/MEM and MEM/WB, or by stalling decode on a load-use dependency. Its in1/in2/sel outputs drive the ALU directly.

---
 rtl/id_ex_stage.sv | 194 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the MIPS datapath. It holds the
// decoded operands and controls, derives the 3-bit ALU select, and resolves
// RAW hazards. Outputs in1/in2/sel feed the ALU directly.
// Build option: FORWARD_EN enables EX/MEM and MEM/WB operand forwarding, so
// only load-use stalls remain. Without it, decode stalls until the producer
// reaches write-back, and the write-first register file covers MEM/WB.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic        id_alusrc,
  input  logic [1:0]  id_aluop,
  input  logic [5:0]  id_funct,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        exm_regwrite,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [2:0]  sel,
  output logic [31:0] ex_rt_data,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread
);

  localparam logic [2:0] SEL_ADD = 3'b010;

  // ALU select: 000 and, 001 or, 010 add, 110 sub, 111 slt.
  function automatic logic [2:0] alu_sel(input logic [1:0] aluop,
                                         input logic [5:0] funct);
    logic [2:0] s;
    s = SEL_ADD;
    case (aluop)
      2'b00: s = SEL_ADD;
      2'b01: s = 3'b110;
      2'b11: s = 3'b001;
      default: begin
        case (funct)
          6'b100000: s = SEL_ADD;
          6'b100010: s = 3'b110;
          6'b100100: s = 3'b000;
          6'b100101: s = 3'b001;
          6'b101010: s = 3'b111;
          default:   s = SEL_ADD;
        endcase
      end
    endcase
    return s;
  endfunction

  logic        valid_q, valid_d;
  logic [4:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [31:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic        alusrc_q, alusrc_d, regwrite_q, regwrite_d, memread_q, memread_d;
  logic [2:0]  sel_q, sel_d;

  logic        advance, hazard, id_hits_ex;
  logic [31:0] op_a, op_b;

`ifdef FORWARD_EN
  // EX/MEM has the younger result, so it wins over MEM/WB; r0 never forwards.
  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] held,
                                      input logic e_we, input logic [4:0] e_rd,
                                      input logic [31:0] e_val, input logic w_we,
                                      input logic [4:0] w_rd, input logic [31:0] w_val);
    logic [31:0] v;
    v = held;
    if (e_we && e_rd != 5'd0 && e_rd == src)      v = e_val;
    else if (w_we && w_rd != 5'd0 && w_rd == src) v = w_val;
    return v;
  endfunction

  // Operand selection with forwarding from the later stages.
  always_comb begin
    op_a = fwd(rs_q, rs_data_q, exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_data);
    op_b = fwd(rt_q, rt_data_q, exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_data);
  end
`else
  // Source indices and later-stage values are only needed for forwarding.
  logic unused_fwd;
  assign unused_fwd = ^{rs_q, rt_q, exm_result, wb_regwrite, wb_rd, wb_data};

  // Without forwarding the held register-file values are already current.
  always_comb begin
    op_a = rs_data_q;
    op_b = rt_data_q;
  end
`endif

  // Hazard detection and the handshake toward decode.
  always_comb begin
    id_hits_ex = (rd_q != 5'd0) && (rd_q == id_rs || rd_q == id_rt);
    hazard     = valid_q && memread_q && id_hits_ex;
`ifndef FORWARD_EN
    if (valid_q && regwrite_q && id_hits_ex)
      hazard = 1'b1;
    if (exm_regwrite && exm_rd != 5'd0 && (exm_rd == id_rs || exm_rd == id_rt))
      hazard = 1'b1;
`endif
    advance  = !valid_q || ex_ready;
    id_ready = advance && !hazard && !flush;
  end

  // Next-state: flush kills, advance captures or bubbles, otherwise hold.
  always_comb begin
    valid_d    = valid_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (advance) begin
      if (id_valid && id_ready) begin
        valid_d    = 1'b1;
        rs_d       = id_rs;
        rt_d       = id_rt;
        rs_data_d  = id_rs_data;
        rt_data_d  = id_rt_data;
        imm_d      = id_imm;
        alusrc_d   = id_alusrc;
        sel_d      = alu_sel(id_aluop, id_funct);
        rd_d       = id_rd;
        regwrite_d = id_regwrite;
        memread_d  = id_memread;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Stage register; reset clears everything and parks the select on add.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      sel_q      <= SEL_ADD;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
    end
  end

  // Outputs to the ALU and downstream stages.
  always_comb begin
    ex_valid    = valid_q;
    in1         = op_a;
    in2         = alusrc_q ? imm_q : op_b;
    ex_rt_data  = op_b;
    sel         = sel_q;
    ex_rd       = rd_q;
    ex_regwrite = regwrite_q;
    ex_memread  = memread_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; the FORWARD_EN-specific steps follow the
// same macro as the design.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset, id_valid, id_ready;
  logic [4:0]  id_rs, id_rt, id_rd, exm_rd, wb_rd, ex_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm, exm_result, wb_data;
  logic        id_alusrc, id_regwrite, id_memread, exm_regwrite, wb_regwrite;
  logic [1:0]  id_aluop;
  logic [5:0]  id_funct;
  logic        ex_ready, flush, ex_valid, ex_regwrite, ex_memread;
  logic [31:0] in1, in2, ex_rt_data;
  logic [2:0]  sel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_funct(id_funct),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid), .in1(in1), .in2(in2),
    .sel(sel), .ex_rt_data(ex_rt_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] imm, input logic alusrc,
                       input logic [1:0] aluop, input logic [5:0] funct,
                       input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_alusrc = alusrc; id_aluop = aluop; id_funct = funct;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    offer(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_valid = 1'b0;
    exm_regwrite = 1'b0; exm_rd = 0; exm_result = 0;
    wb_regwrite = 1'b0; wb_rd = 0; wb_data = 0;
    tick(); tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_in1", in1, 0);
    chk("rst_in2", in2, 0);
    chk("rst_sel", sel, 3'b010);
    chk("rst_rtdata", ex_rt_data, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_rw", ex_regwrite, 0);
    chk("rst_mr", ex_memread, 0);
    reset = 1'b0; #1;
    chk("rst_ready", id_ready, 1);

    // slt capture, one cycle latency
    offer(1, 5, 32'd5, 32'd9, 0, 0, 2'b10, 6'b101010, 7, 0, 0);
    tick();
    chk("slt_valid", ex_valid, 1);
    chk("slt_sel", sel, 3'b111);
    chk("slt_in1", in1, 5);
    chk("slt_in2", in2, 9);
    chk("slt_rd", ex_rd, 7);
    // ori style with immediate
    offer(2, 6, 32'd3, 32'h44, 32'h100, 1, 2'b11, 0, 8, 0, 0);
    tick();
    chk("or_sel", sel, 3'b001);
    chk("or_in1", in1, 3);
    chk("or_in2", in2, 32'h100);
    chk("or_rtdata", ex_rt_data, 32'h44);
    offer(1, 2, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0); tick();
    chk("sub_sel", sel, 3'b110);
    offer(1, 2, 0, 0, 0, 0, 2'b10, 6'b100100, 0, 0, 0); tick();
    chk("and_sel", sel, 3'b000);
    offer(1, 2, 0, 0, 0, 0, 2'b10, 6'b100101, 0, 0, 0); tick();
    chk("ror_sel", sel, 3'b001);
    offer(1, 2, 0, 0, 0, 0, 2'b10, 6'b100010, 0, 0, 0); tick();
    chk("rsub_sel", sel, 3'b110);
    offer(1, 2, 0, 0, 0, 0, 2'b10, 6'b111111, 0, 0, 0); tick();
    chk("dflt_sel", sel, 3'b010);
    id_valid = 1'b0; tick();
    chk("bubble_valid", ex_valid, 0);

    // back-end stall for three cycles
    offer(1, 2, 32'h1A, 0, 0, 0, 2'b01, 0, 9, 0, 0); tick();
    ex_ready = 1'b0;
    offer(3, 4, 32'h2B, 0, 0, 0, 2'b11, 0, 0, 0, 0); #1;
    chk("stall_ready", id_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", ex_valid, 1);
      chk("stall_in1", in1, 32'h1A);
      chk("stall_sel", sel, 3'b110);
      chk("stall_ready_hold", id_ready, 0);
    end
    ex_ready = 1'b1; tick();
    chk("resume_in1", in1, 32'h2B);
    chk("resume_sel", sel, 3'b001);

    // flush with a valid decode offer
    offer(5, 6, 32'h3C, 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b1; #1;
    chk("flush_ready", id_ready, 0);
    tick();
    chk("flush_valid", ex_valid, 0);
    flush = 1'b0;
    // flush while the back end is stalled
    offer(5, 6, 32'h4D, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    id_valid = 1'b0;
    chk("pre_fst_valid", ex_valid, 1);
    ex_ready = 1'b0; flush = 1'b1; tick();
    chk("flush_stall_valid", ex_valid, 0);
    flush = 1'b0; ex_ready = 1'b1;
    // reset during a stall
    offer(1, 2, 32'h77, 0, 0, 0, 2'b01, 0, 5, 1, 0); tick();
    id_valid = 1'b0; ex_ready = 1'b0; tick();
    chk("pre_rst_valid", ex_valid, 1);
    reset = 1'b1; tick();
    chk("mrst_valid", ex_valid, 0);
    chk("mrst_in1", in1, 0);
    chk("mrst_sel", sel, 3'b010);
    chk("mrst_rd", ex_rd, 0);
    chk("mrst_rw", ex_regwrite, 0);
    reset = 1'b0; ex_ready = 1'b1;

    // load-use: lw r4, then a reader of r4
    offer(1, 4, 0, 0, 32'd8, 1, 2'b00, 0, 4, 1, 1); tick();
    chk("lw_memread", ex_memread, 1);
    offer(4, 6, 32'hDEAD, 0, 0, 0, 2'b00, 0, 10, 0, 0); #1;
    chk("lu_ready", id_ready, 0);
    tick();
    chk("lu_bubble", ex_valid, 0);
    exm_regwrite = 1'b1; exm_rd = 4; exm_result = 32'h1008;
`ifdef FORWARD_EN
    #1;
    chk("lu_ready_after", id_ready, 1);
    tick();
    exm_regwrite = 1'b0; wb_regwrite = 1'b1; wb_rd = 4; wb_data = 32'hABC; #1;
`else
    #1;
    chk("lu_ready_exm", id_ready, 0);
    tick();
    chk("lu_bubble2", ex_valid, 0);
    exm_regwrite = 1'b0; wb_regwrite = 1'b1; wb_rd = 4; wb_data = 32'hABC;
    id_rs_data = 32'hABC; #1;
    chk("lu_ready_after", id_ready, 1);
    tick();
`endif
    chk("lu_valid", ex_valid, 1);
    chk("lu_in1", in1, 32'hABC);
    id_valid = 1'b0; wb_regwrite = 1'b0;
    tick();

`ifdef FORWARD_EN
    // forwarding priority and register 0
    offer(3, 5, 32'h33, 32'h55, 32'h9, 1, 2'b00, 0, 0, 0, 0); tick();
    id_valid = 1'b0;
    exm_regwrite = 1'b1; exm_rd = 3; exm_result = 32'h11;
    wb_regwrite = 1'b1; wb_rd = 3; wb_data = 32'h22; #1;
    chk("fwd_exm", in1, 32'h11);
    exm_regwrite = 1'b0; #1;
    chk("fwd_wb", in1, 32'h22);
    wb_rd = 5; #1;
    chk("fwd_held_rs", in1, 32'h33);
    chk("fwd_rt_wb", ex_rt_data, 32'h22);
    chk("fwd_in2_imm", in2, 32'h9);
    exm_regwrite = 1'b1; exm_rd = 5; #1;
    chk("fwd_rt_exm", ex_rt_data, 32'h11);
    exm_regwrite = 1'b0; wb_regwrite = 1'b0;
    offer(0, 0, 32'h66, 32'h77, 0, 0, 2'b00, 0, 0, 0, 0); tick();
    id_valid = 1'b0;
    exm_regwrite = 1'b1; exm_rd = 0; wb_regwrite = 1'b1; wb_rd = 0; #1;
    chk("r0_in1", in1, 32'h66);
    chk("r0_in2", in2, 32'h77);
    exm_regwrite = 1'b0; wb_regwrite = 1'b0;
`else
    // add r2 then sub reading r2: two stall cycles
    offer(1, 1, 0, 0, 0, 0, 2'b00, 0, 2, 1, 0); tick();
    offer(2, 3, 32'hBAD, 0, 0, 0, 2'b01, 0, 0, 0, 0); #1;
    chk("raw_ready_ex", id_ready, 0);
    tick();
    chk("raw_bubble1", ex_valid, 0);
    exm_regwrite = 1'b1; exm_rd = 2; #1;
    chk("raw_ready_exm", id_ready, 0);
    tick();
    chk("raw_bubble2", ex_valid, 0);
    exm_regwrite = 1'b0; wb_regwrite = 1'b1; wb_rd = 2; id_rs_data = 32'h222; #1;
    chk("raw_ready_wb", id_ready, 1);
    tick();
    id_valid = 1'b0;
    chk("raw_valid", ex_valid, 1);
    chk("raw_in1", in1, 32'h222);
    chk("raw_sel", sel, 3'b110);
    exm_regwrite = 1'b1; exm_rd = 2; exm_result = 32'h999; #1;
    chk("nofwd_in1", in1, 32'h222);
    exm_regwrite = 1'b0; wb_regwrite = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
